// File: rtl/seq_correlator.sv
// Streaming convolver / cross-correlator: loads two N-sample sequences, then
// emits all 2N-1 terms from a single multiply-accumulate, one product per cycle.
module seq_correlator #(
  parameter int N = 4,
  parameter int W = 4,
  localparam int OW = 2 * W + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_y,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int CW = $clog2(N);
  localparam int NW = $clog2(2 * N - 1);
  // Signed index wide enough for -(N-1) .. 3N-3
  localparam int JW = NW + 2;

  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] OUTPUT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        k_q, k_d;
  logic [NW-1:0]        n_q, n_d;
  logic [OW-1:0]        acc_q, acc_d;
  logic                 mode_q, mode_d;

  logic [W-1:0]         x_mem [N];
  logic [W-1:0]         y_mem [N];

  logic                 load_we;
  logic signed [JW-1:0] j_s;
  logic                 j_ok;
  logic [CW-1:0]        j_idx;
  logic [2*W-1:0]       prod;

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign out_valid = (state_q == OUTPUT);
  assign out_last  = (state_q == OUTPUT) && (n_q == NW'(2 * N - 2));
  assign out_data  = acc_q;
  assign load_we   = (state_q == LOAD) && in_valid;

  // y index for the current product; out-of-range indices contribute zero
  always_comb begin
    j_s   = mode_q ? JW'(k_q) + JW'(n_q) - JW'(N - 1)
                   : JW'(n_q) - JW'(k_q);
    j_ok  = !j_s[JW-1] && (j_s[JW-2:0] <= (JW-1)'(N - 1));
    j_idx = j_s[CW-1:0];
    prod  = j_ok ? (2 * W)'(x_mem[k_q]) * (2 * W)'(y_mem[j_idx]) : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    n_d     = n_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (cnt_q == '0) mode_d = in_mode;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            n_d     = '0;
            k_d     = '0;
            acc_d   = '0;
            state_d = COMPUTE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      COMPUTE: begin
        acc_d = acc_q + OW'(prod);
        if (k_q == CW'(N - 1)) state_d = OUTPUT;
        else                   k_d     = k_q + CW'(1);
      end
      OUTPUT: begin
        if (out_ready) begin
          if (n_q == NW'(2 * N - 2)) begin
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            n_d     = n_q + NW'(1);
            k_d     = '0;
            acc_d   = '0;
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
    end
  end

  // Sample memories carry no reset; contents are rewritten by every block
  always_ff @(posedge clk) begin
    if (load_we) begin
      x_mem[cnt_q] <= in_x;
      y_mem[cnt_q] <= in_y;
    end
  end

endmodule
